adder_share_arbiter: RTL

//  Shares one WIDTH-bit parametric adder among N_REQ requesters, in round-robin order.

---
 rtl/adder_share_arbiter_pkg.sv | 17 +
 rtl/adder_share_arbiter_rr_arbiter.sv | 44 ++++
 rtl/adder_share_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/adder_share_arbiter_pkg.sv
// Purpose: shared types and defaults for the adder-sharing arbiter slice.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
// Contents: FSM state encoding (S_IDLE/S_HOLD) and default WIDTH/N_REQ values.
package adder_share_arbiter_pkg;

  // Default datapath width and requester count.
  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_REQ = 4;

  // S_IDLE: response slot empty. S_HOLD: resp_sum/resp_id hold a valid result.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Purpose: round-robin grant among N requesters, starting after last_grant.
// Latency: combinational.
// Backpressure: enable=0 forces an all-zero grant.
// Ports: req (N) in, last_grant (IDX_W) in, enable in,
//        grant (N, one-hot) out, grant_idx (IDX_W) out, grant_vld out.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             enable,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  int               idx;
  logic [IDX_W-1:0] idx_l;
  logic             found;

  // Walk the ring starting one past the previous winner; the previous
  // winner itself is examined last, which gives the starvation bound.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    idx_l     = '0;
    if (enable) begin
      for (int k = 1; k <= N; k++) begin
        idx   = (int'(last_grant) + k) % N;
        idx_l = IDX_W'(idx);
        if (!found && req[idx_l]) begin
          found        = 1'b1;
          grant[idx_l] = 1'b1;
          grant_idx    = idx_l;
        end
      end
    end
    grant_vld = found;
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Purpose: one WIDTH-bit adder shared round-robin by N_REQ valid/ready requesters.
// Latency: 1 cycle from accepted request to resp_valid; 1 result per cycle with resp_ready high.
// Backpressure: resp_ready low holds the result stable and drops every req_ready.
// Ports: clk, rst (async, active-high); req_valid/req_ready (N_REQ), req_a/req_b
//        (N_REQ*WIDTH, slice i = [i*WIDTH +: WIDTH]); resp_valid/resp_ready,
//        resp_id (ID_W), resp_sum (WIDTH), resp_carry (only with ADDER_CARRY_EN).
// Build option: define ADDER_CARRY_EN to expose the registered carry-out.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
`ifdef ADDER_CARRY_EN
  output logic [WIDTH-1:0]       resp_sum,
  output logic                   resp_carry
`else
  output logic [WIDTH-1:0]       resp_sum
`endif
);

  state_t           state_q, state_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [WIDTH-1:0] sum_q, sum_d;

  logic             slot_free;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_vld;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] add_sum;

  // The slot is reusable either when empty or when the current result
  // leaves at this same edge, which allows back-to-back grants.
  assign slot_free = (state_q == S_IDLE) | (resp_ready & resp_valid);

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_q),
    .enable     (slot_free),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_vld  (grant_vld)
  );

  assign req_ready = grant;

  // One-hot AND-OR operand mux; zero when nothing is granted.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        op_a = op_a | req_a[i*WIDTH +: WIDTH];
        op_b = op_b | req_b[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef ADDER_CARRY_EN
  logic [WIDTH:0] add_full;
  logic           carry_q, carry_d;

  assign add_full = {1'b0, op_a} + {1'b0, op_b};
  assign add_sum  = add_full[WIDTH-1:0];

  always_comb begin
    carry_d = carry_q;
    if (grant_vld) begin
      carry_d = add_full[WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

  assign resp_carry = carry_q;
`else
  assign add_sum = op_a + op_b;
`endif

  // Next-state and response-register load.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    sum_d   = sum_q;
    if (grant_vld) begin
      last_d = grant_idx;
      id_d   = grant_idx;
      sum_d  = add_sum;
    end
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (resp_ready && !grant_vld) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= ID_W'(N_REQ - 1);
      id_q    <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
    end
  end

  assign resp_valid = (state_q == S_HOLD);
  assign resp_id    = id_q;
  assign resp_sum   = sum_q;

endmodule
